gslcd_timing: RTL and testbench
===============================

# gslcd_timing

Raster timing generator for the GameSlab LCD controller, running in the pixel-clock domain. It produces horizontal sync, vertical sync and active-video strobes for a progressive frame built from configurable active/porch/sync segments. The pixel fetch/output stage consumes these strobes. A single enable starts and stops the raster cleanly from the frame origin.

## Interface
- H_ACTIVE, 320, visible pixels per line
- H_FP, 20, horizontal front porch (pclk cycles)
- H_SYNC, 30, hsync width (pclk cycles)
- H_BP, 38, horizontal back porch (pclk cycles)
- V_ACTIVE, 240, visible lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 15, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, 1 = syncs asserted high; 0 = asserted low
- pclk_clk  in  1  pixel clock, sole clock
- pclk_reset  in  1  reset; one clock; asynchronous, active-high
- io_enable  in  1  run raster when high; hold at origin when low
- io_hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- io_vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- io_active  out  1  high during visible pixels

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 408); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 262).
- Constraints: H_ACTIVE, H_SYNC, V_ACTIVE, V_SYNC ≥ 1; porches ≥ 0. Counter widths = $clog2(total), minimum 1.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). Segment order within each axis: active, front porch, sync, back porch.
- Decode: active = (h < H_ACTIVE) && (v < V_ACTIVE). hsync asserted when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line, including vertical blanking. vsync asserted for whole lines with V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. vsync edges align with h = 0.
- Enable high at an edge: output registers load decode(h,v); h increments. At h = H_TOTAL-1, h wraps to 0 and v increments. At v = V_TOTAL-1 with h wrap, v wraps to 0. Free-running frames, no gaps.
- Enable low at an edge: h, v cleared to 0; outputs driven inactive: active = 0, syncs deasserted.
- Reset: h = v = 0, io_active = 0, io_hsync/io_vsync at deasserted level. Reset mid-frame aborts immediately.

## Timing
- All outputs registered, glitch-free.
- First edge with io_enable = 1 after idle: io_active rises at that edge (pixel 0, line 0). Exactly 1 edge latency.
- io_active high for H_ACTIVE consecutive cycles per visible line. Line period is H_TOTAL cycles. Frame period is H_TOTAL×V_TOTAL cycles (default 106896).
- io_hsync asserts H_ACTIVE+H_FP cycles after io_active rises on a line (default 340) and stays asserted H_SYNC cycles.
- io_vsync asserts (V_ACTIVE+V_FP)×H_TOTAL cycles after frame start and stays asserted V_SYNC×H_TOTAL cycles.
- Enable drop mid-frame: outputs inactive at the next edge. Re-enable restarts at pixel 0, line 0.

## Configuration
- GSLCD_TIMING_POS_EN defined: adds outputs io_x [$clog2(H_TOTAL)-1:0] and io_y [$clog2(V_TOTAL)-1:0].
  - These are registered copies of the h and v values decoded into the current outputs, aligned with io_active.
  - They reset to 0 and read 0 while disabled.
- Not defined: those ports and registers are absent. Behaviour is otherwise identical.

## Structure
- Package gslcd_pkg holds:
  - default timing constants (H_/V_ ACTIVE, FP, SYNC, BP)
  - derived totals
  - sync polarity constant
- One sub-module, gslcd_axis_counter, instantiated twice (horizontal and vertical):
  - wrap counter with advance input, clear input and wrap output
  - in-active and in-sync decode outputs
  - the vertical instance advances on the horizontal wrap

## Test plan
- Reset held, enable 0 (default params) -> io_active = 0, io_hsync = io_vsync = 1 (active-low deasserted); unchanged while enable stays 0.
- Enable rises after reset -> io_active high at the first enabled edge for 320 cycles, then low 88; io_hsync low at cycles 340..369 of each line.
- Run one full frame -> io_vsync low from line 244 for exactly 3×408 = 1224 cycles. Next frame's io_active rises 106896 cycles after the first.
- Drop enable mid-line on line 100, re-enable 50 cycles later -> outputs inactive the edge after the drop. Restart at pixel 0, line 0, with io_active rising on the first re-enabled edge.
- Assert pclk_reset asynchronously mid-frame while hsync is asserted -> outputs go inactive immediately without waiting for an edge. Raster restarts from origin after release.
- SYNC_ACTIVE_HIGH = 1 with GSLCD_TIMING_POS_EN -> sync pulses inverted with identical timing; io_x runs 0..319 and io_y 0..239 while io_active is high.

Source files
------------

// File: rtl/gslcd_pkg.sv
// Shared timing defaults and helpers for the GameSlab LCD raster timing generator.
package gslcd_pkg;

    // Default horizontal segments, in pixel clocks
    localparam int unsigned GSLCD_H_ACTIVE = 320;
    localparam int unsigned GSLCD_H_FP     = 20;
    localparam int unsigned GSLCD_H_SYNC   = 30;
    localparam int unsigned GSLCD_H_BP     = 38;

    // Default vertical segments, in lines
    localparam int unsigned GSLCD_V_ACTIVE = 240;
    localparam int unsigned GSLCD_V_FP     = 4;
    localparam int unsigned GSLCD_V_SYNC   = 3;
    localparam int unsigned GSLCD_V_BP     = 15;

    // Derived totals for the default raster
    localparam int unsigned GSLCD_H_TOTAL =
        GSLCD_H_ACTIVE + GSLCD_H_FP + GSLCD_H_SYNC + GSLCD_H_BP;
    localparam int unsigned GSLCD_V_TOTAL =
        GSLCD_V_ACTIVE + GSLCD_V_FP + GSLCD_V_SYNC + GSLCD_V_BP;

    // Sync polarity: 1 = asserted high, 0 = asserted low
    localparam bit GSLCD_SYNC_ACTIVE_HIGH = 1'b0;

    // Counter width for a 0..total-1 counter, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 32'd1) ? 32'($clog2(total)) : 32'd1;
    endfunction

endpackage

// File: rtl/gslcd_axis_counter.sv
// One raster axis: wrap counter plus active/sync segment decode.
// Segment order along the axis is active, front porch, sync, back porch.
module gslcd_axis_counter
    import gslcd_pkg::*;
#(
    parameter  int unsigned ACTIVE = 1,
    parameter  int unsigned FP     = 0,
    parameter  int unsigned SYNC   = 1,
    parameter  int unsigned BP     = 0,
    localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W      = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap_c,
    output logic         in_active_c,
    output logic         in_sync_c
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam int unsigned  SYNC_START = ACTIVE + FP;
    localparam int unsigned  SYNC_END   = ACTIVE + FP + SYNC;

    // Segment decode of the current count
    always_comb begin
        wrap_c      = advance && (count == LAST);
        in_active_c = 32'(count) < ACTIVE;
        in_sync_c   = (32'(count) >= SYNC_START) && (32'(count) < SYNC_END);
    end

    // Count register: clear has priority, otherwise step and wrap on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/gslcd_timing.sv
// Raster timing generator: registered hsync, vsync and active strobes in the
// pixel-clock domain. Defining GSLCD_TIMING_POS_EN adds io_x/io_y position
// outputs aligned with io_active.
module gslcd_timing
    import gslcd_pkg::*;
#(
    parameter  int unsigned H_ACTIVE         = GSLCD_H_ACTIVE,
    parameter  int unsigned H_FP             = GSLCD_H_FP,
    parameter  int unsigned H_SYNC           = GSLCD_H_SYNC,
    parameter  int unsigned H_BP             = GSLCD_H_BP,
    parameter  int unsigned V_ACTIVE         = GSLCD_V_ACTIVE,
    parameter  int unsigned V_FP             = GSLCD_V_FP,
    parameter  int unsigned V_SYNC           = GSLCD_V_SYNC,
    parameter  int unsigned V_BP             = GSLCD_V_BP,
    parameter  bit          SYNC_ACTIVE_HIGH = GSLCD_SYNC_ACTIVE_HIGH,
    localparam int unsigned H_TOTAL          = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL          = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW               = cnt_width(H_TOTAL),
    localparam int unsigned VW               = cnt_width(V_TOTAL)
) (
    input  logic          pclk_clk,
    input  logic          pclk_reset,
    input  logic          io_enable,
    output logic          io_hsync,
    output logic          io_vsync,
`ifdef GSLCD_TIMING_POS_EN
    output logic          io_active,
    output logic [HW-1:0] io_x,
    output logic [VW-1:0] io_y
`else
    output logic          io_active
`endif
);

    localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH;
    localparam logic SYNC_OFF = ~SYNC_ACTIVE_HIGH;

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap_c;
    logic          h_active_c;
    logic          h_sync_c;
    logic          v_wrap_unused;
    logic          v_active_c;
    logic          v_sync_c;
    logic          idle_c;

    assign idle_c = !io_enable;

    // Horizontal axis: steps every enabled pixel clock
    gslcd_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk         (pclk_clk),
        .rst         (pclk_reset),
        .advance     (io_enable),
        .clear       (idle_c),
        .count       (h_count),
        .wrap_c      (h_wrap_c),
        .in_active_c (h_active_c),
        .in_sync_c   (h_sync_c)
    );

    // Vertical axis: steps on each horizontal wrap, so vsync edges sit at h = 0
    gslcd_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk         (pclk_clk),
        .rst         (pclk_reset),
        .advance     (h_wrap_c),
        .clear       (idle_c),
        .count       (v_count),
        .wrap_c      (v_wrap_unused),
        .in_active_c (v_active_c),
        .in_sync_c   (v_sync_c)
    );

    // Output strobes: load decode of the current position, inactive when idle
    always_ff @(posedge pclk_clk or posedge pclk_reset) begin
        if (pclk_reset) begin
            io_active <= 1'b0;
            io_hsync  <= SYNC_OFF;
            io_vsync  <= SYNC_OFF;
        end else if (!io_enable) begin
            io_active <= 1'b0;
            io_hsync  <= SYNC_OFF;
            io_vsync  <= SYNC_OFF;
        end else begin
            io_active <= h_active_c && v_active_c;
            io_hsync  <= h_sync_c ? SYNC_ON : SYNC_OFF;
            io_vsync  <= v_sync_c ? SYNC_ON : SYNC_OFF;
        end
    end

`ifdef GSLCD_TIMING_POS_EN
    // Position outputs: the h/v pair that produced the current strobes
    always_ff @(posedge pclk_clk or posedge pclk_reset) begin
        if (pclk_reset) begin
            io_x <= '0;
            io_y <= '0;
        end else if (!io_enable) begin
            io_x <= '0;
            io_y <= '0;
        end else begin
            io_x <= h_count;
            io_y <= v_count;
        end
    end
`else
    // Counts are only consumed by the position outputs
    logic unused_counts;
    assign unused_counts = ^{h_count, v_count};
`endif

endmodule

// File: tb/tb_gslcd_timing.sv
// Directed bench for gslcd_timing: a default-parameter instance (active-low
// syncs) and a small-raster instance (active-high syncs) share clock, reset
// and enable so frame-level behaviour is visible within a short run.
module tb_gslcd_timing;

    // Default raster, hand-derived: 320+20+30+38 = 408, 240+4+3+15 = 262
    localparam int D_HT  = 408;
    localparam int D_VT  = 262;
    localparam int D_HA  = 320;
    localparam int D_VA  = 240;
    localparam int D_HS0 = 340;
    localparam int D_HS1 = 370;
    localparam int D_VS0 = 244;
    localparam int D_VS1 = 247;

    // Small raster: H 8/2/3/1 = 14, V 5/1/2/2 = 10
    localparam int S_HT  = 14;
    localparam int S_VT  = 10;
    localparam int S_HA  = 8;
    localparam int S_VA  = 5;
    localparam int S_HS0 = 10;
    localparam int S_HS1 = 13;
    localparam int S_VS0 = 6;
    localparam int S_VS1 = 8;

    logic clk;
    logic rst;
    logic en;

    logic d_hsync, d_vsync, d_active;
    logic s_hsync, s_vsync, s_active;
`ifdef GSLCD_TIMING_POS_EN
    logic [8:0] d_x, d_y;
    logic [3:0] s_x, s_y;
`endif

    int vectors;
    int miscompares;
    int cur_n;

    gslcd_timing u_dut (
        .pclk_clk   (clk),
        .pclk_reset (rst),
        .io_enable  (en),
        .io_hsync   (d_hsync),
        .io_vsync   (d_vsync),
`ifdef GSLCD_TIMING_POS_EN
        .io_active  (d_active),
        .io_x       (d_x),
        .io_y       (d_y)
`else
        .io_active  (d_active)
`endif
    );

    gslcd_timing #(
        .H_ACTIVE         (8),
        .H_FP             (2),
        .H_SYNC           (3),
        .H_BP             (1),
        .V_ACTIVE         (5),
        .V_FP             (1),
        .V_SYNC           (2),
        .V_BP             (2),
        .SYNC_ACTIVE_HIGH (1'b1)
    ) u_small (
        .pclk_clk   (clk),
        .pclk_reset (rst),
        .io_enable  (en),
        .io_hsync   (s_hsync),
        .io_vsync   (s_vsync),
`ifdef GSLCD_TIMING_POS_EN
        .io_active  (s_active),
        .io_x       (s_x),
        .io_y       (s_y)
`else
        .io_active  (s_active)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (n=%0d): got %0h, expected %0h", tag, cur_n, got, exp);
        end
    endtask

    // Idle/reset levels: active low, syncs deasserted, positions zero
    task automatic check_idle(input string tag);
        check({tag, "_d_active"}, 32'(d_active), 32'd0);
        check({tag, "_d_hsync"},  32'(d_hsync),  32'd1);
        check({tag, "_d_vsync"},  32'(d_vsync),  32'd1);
        check({tag, "_s_active"}, 32'(s_active), 32'd0);
        check({tag, "_s_hsync"},  32'(s_hsync),  32'd0);
        check({tag, "_s_vsync"},  32'(s_vsync),  32'd0);
`ifdef GSLCD_TIMING_POS_EN
        check({tag, "_d_x"}, 32'(d_x), 32'd0);
        check({tag, "_d_y"}, 32'(d_y), 32'd0);
        check({tag, "_s_x"}, 32'(s_x), 32'd0);
        check({tag, "_s_y"}, 32'(s_y), 32'd0);
`endif
    endtask

    // Expected strobes n edges after the first enabled edge (n = 0 is origin)
    task automatic check_raster(input int n);
        int dh, dv, sh, sv;
        dh = n % D_HT;
        dv = (n / D_HT) % D_VT;
        sh = n % S_HT;
        sv = (n / S_HT) % S_VT;
        cur_n = n;
        check("d_active", 32'(d_active), 32'((dh < D_HA) && (dv < D_VA)));
        check("d_hsync",  32'(d_hsync),  32'(!((dh >= D_HS0) && (dh < D_HS1))));
        check("d_vsync",  32'(d_vsync),  32'(!((dv >= D_VS0) && (dv < D_VS1))));
        check("s_active", 32'(s_active), 32'((sh < S_HA) && (sv < S_VA)));
        check("s_hsync",  32'(s_hsync),  32'((sh >= S_HS0) && (sh < S_HS1)));
        check("s_vsync",  32'(s_vsync),  32'((sv >= S_VS0) && (sv < S_VS1)));
`ifdef GSLCD_TIMING_POS_EN
        check("d_x", 32'(d_x), 32'(dh));
        check("d_y", 32'(d_y), 32'(dv));
        check("s_x", 32'(s_x), 32'(sh));
        check("s_y", 32'(s_y), 32'(sv));
`endif
    endtask

    // Run count enabled edges from the origin, checking each one
    task automatic run_raster(input int count);
        for (int n = 0; n < count; n++) begin
            @(posedge clk);
            #1;
            check_raster(n);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur_n       = -1;
        rst         = 1'b1;
        en          = 1'b0;

        // Reset held with enable low
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // Still idle while enable stays low
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle");
        end

        // Run to line 100, pixel 150 of the default raster (many small frames)
        en = 1'b1;
        run_raster(100 * D_HT + 150);

        // Drop enable mid-line: inactive from the next edge, for 50 cycles
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            cur_n = i;
            check_idle("drop");
        end

        // Re-enable: restart at origin; stop with default hsync asserted
        en = 1'b1;
        run_raster(D_HS0 + 6);
        cur_n = D_HS0 + 5;
        check("pre_rst_hsync", 32'(d_hsync), 32'd0);

        // Asynchronous reset between edges clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_hold");
        rst = 1'b0;

        // Raster restarts from origin after release (enable held high)
        run_raster(3 * S_HT * S_VT + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
